// File: rtl/fuel_pump_pkg.sv
// Shared types and default parameters for the fuel pump anti-theft sequencer.
package fuel_pump_pkg;

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StWaitBrake  = 3'd1,
    StWaitHidden = 3'd2,
    StRun        = 3'd3,
    StLockout    = 3'd4
  } fuel_state_t;

  localparam int unsigned DefTimeoutCycles  = 8;
  localparam int unsigned DefLockoutCycles  = 16;
  localparam int unsigned DefMaxFails       = 3;
  localparam int unsigned DefDebounceCycles = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fuel_pump_sequencer_if.sv
// Cabin switch inputs and relay/status outputs of the fuel pump sequencer.
interface fuel_pump_sequencer_if;
  logic       ignition;
  logic       brake;
  logic       hidden;
  logic       fuelPumpPower;
  logic       alarm;
  logic [2:0] stateOut;

  modport master (
    output ignition, brake, hidden,
    input  fuelPumpPower, alarm, stateOut
  );

  modport slave (
    input  ignition, brake, hidden,
    output fuelPumpPower, alarm, stateOut
  );
endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchronizer for one raw switch, with an optional stable-sample filter
// enabled by FUEL_PUMP_DEBOUNCE_EN.
module input_debouncer
`ifdef FUEL_PUMP_DEBOUNCE_EN
#(
  parameter int unsigned DEBOUNCE_CYCLES = fuel_pump_pkg::DefDebounceCycles
)
`endif
(
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic sync_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
    end
  end

`ifdef FUEL_PUMP_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            filt_q;

  // Counts consecutive samples that disagree with the filtered value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync_q[1] == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
      filt_q <= sync_q[1];
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign sync_o = filt_q;
`else
  assign sync_o = sync_q[1];
`endif

endmodule

// File: rtl/fuel_pump_sequencer.sv
// Anti-theft start sequencer gating the fuel pump relay: ignition, brake, then a fresh
// hidden-switch press within a window. FUEL_PUMP_DEBOUNCE_EN adds input filtering.
module fuel_pump_sequencer
  import fuel_pump_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES  = DefTimeoutCycles,
  parameter int unsigned LOCKOUT_CYCLES  = DefLockoutCycles,
  parameter int unsigned MAX_FAILS       = DefMaxFails
`ifdef FUEL_PUMP_DEBOUNCE_EN
  ,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
`endif
) (
  input logic                  clock,
  input logic                  reset,
  fuel_pump_sequencer_if.slave bus
);

  localparam int unsigned TimerW = $clog2(max_u(TIMEOUT_CYCLES, LOCKOUT_CYCLES) + 1);
  localparam int unsigned FailW  = $clog2(MAX_FAILS + 1);

  logic [2:0] raw, synced;
  logic       ign, brk, hid, hid_prev_q, hid_rise;

  assign raw = {bus.ignition, bus.brake, bus.hidden};

  for (genvar i = 0; i < 3; i++) begin : g_in
    input_debouncer
`ifdef FUEL_PUMP_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
    u_deb (
      .clock  (clock),
      .reset  (reset),
      .raw_i  (raw[i]),
      .sync_o (synced[i])
    );
  end

  assign {ign, brk, hid} = synced;
  // Only a fresh edge arms; a switch held down never starts the pump.
  assign hid_rise = hid & ~hid_prev_q;

  fuel_state_t       state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [FailW-1:0]  fail_q, fail_d, fail_inc;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    fail_d   = fail_q;
    fail_inc = (fail_q == FailW'(MAX_FAILS)) ? fail_q : fail_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (ign) state_d = StWaitBrake;
      end
      StWaitBrake: begin
        if (!ign) begin
          state_d = StIdle;
        end else if (brk) begin
          state_d = StWaitHidden;
          timer_d = '0;
        end
      end
      StWaitHidden: begin
        if (!ign) begin
          state_d = StIdle;
        end else if (!brk) begin
          state_d = StWaitBrake;
        end else if (hid_rise) begin
          state_d = StRun;
          fail_d  = '0;
        end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
          fail_d  = fail_inc;
          timer_d = '0;
          state_d = (fail_inc == FailW'(MAX_FAILS)) ? StLockout : StWaitBrake;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StRun: begin
        if (!ign) state_d = StIdle;
      end
      StLockout: begin
        if (timer_q == TimerW'(LOCKOUT_CYCLES - 1)) begin
          state_d = StIdle;
          fail_d  = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they move with the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= StIdle;
      timer_q           <= '0;
      fail_q            <= '0;
      hid_prev_q        <= 1'b0;
      bus.fuelPumpPower <= 1'b0;
      bus.alarm         <= 1'b0;
      bus.stateOut      <= 3'd0;
    end else begin
      state_q           <= state_d;
      timer_q           <= timer_d;
      fail_q            <= fail_d;
      hid_prev_q        <= hid;
      bus.fuelPumpPower <= (state_d == StRun);
      bus.alarm         <= (state_d == StLockout);
      bus.stateOut      <= state_d;
    end
  end

endmodule

// File: tb/tb_fuel_pump_sequencer.sv
// Scoreboard bench: stimulus pushes per-cycle expectations from a cycle-count model.
module tb_fuel_pump_sequencer;

  localparam int T  = 8;
  localparam int L  = 16;
  localparam int MF = 3;

  localparam int MIdle = 0, MWaitBrake = 1, MWaitHidden = 2, MRun = 3, MLockout = 4;

  typedef struct packed {
    logic       fpp;
    logic       alarm;
    logic [2:0] st;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  fuel_pump_sequencer_if bus ();

  fuel_pump_sequencer #(
    .TIMEOUT_CYCLES (T),
    .LOCKOUT_CYCLES (L),
    .MAX_FAILS      (MF)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  exp_t       sb[$];
  logic [2:0] hist[$];
  int         passed = 0;
  int         total  = 0;
  int         m_mode, m_entry, m_fails, m_cyc;

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s @%0t: got {fpp,alarm,state}=%b want %b", name, $time, got, want);
  endtask

  function automatic void model_reset();
    m_mode  = MIdle;
    m_entry = 0;
    m_fails = 0;
    m_cyc   = 0;
    hist    = {3'b000, 3'b000, 3'b000};
  endfunction

  // Decision at one clock edge, from inputs driven two (and three) cycles earlier.
  function automatic exp_t model_edge();
    logic [2:0] now, prev;
    bit         ign, brk, rise;
    exp_t       e;
    now  = hist[2];
    prev = hist[3];
    ign  = now[2];
    brk  = now[1];
    rise = now[0] && !prev[0];
    m_cyc++;
    case (m_mode)
      MIdle:      if (ign) m_mode = MWaitBrake;
      MWaitBrake: begin
        if (!ign) m_mode = MIdle;
        else if (brk) begin
          m_mode  = MWaitHidden;
          m_entry = m_cyc;
        end
      end
      MWaitHidden: begin
        if (!ign) m_mode = MIdle;
        else if (!brk) m_mode = MWaitBrake;
        else if (rise) begin
          m_mode  = MRun;
          m_fails = 0;
        end else if (m_cyc - m_entry == T) begin
          m_fails++;
          if (m_fails >= MF) begin
            m_mode  = MLockout;
            m_entry = m_cyc;
          end else begin
            m_mode = MWaitBrake;
          end
        end
      end
      MRun:       if (!ign) m_mode = MIdle;
      MLockout: begin
        if (m_cyc - m_entry == L) begin
          m_mode  = MIdle;
          m_fails = 0;
        end
      end
      default:    m_mode = MIdle;
    endcase
    e.fpp   = (m_mode == MRun);
    e.alarm = (m_mode == MLockout);
    e.st    = 3'(m_mode);
    return e;
  endfunction

  task automatic step(input logic i, input logic b, input logic h);
    @(negedge clock);
    bus.ignition = i;
    bus.brake    = b;
    bus.hidden   = h;
    hist.push_front({i, b, h});
    sb.push_back(model_edge());
    void'(hist.pop_back());
  endtask

  task automatic hold(input int n, input logic i, input logic b, input logic h);
    for (int k = 0; k < n; k++) step(i, b, h);
  endtask

  // Async reset between edges; outputs must drop without a clock edge.
  task automatic apply_reset();
    @(posedge clock);
    #2;
    reset = 1'b1;
    sb.delete();
    bus.ignition = 1'b0;
    bus.brake    = 1'b0;
    bus.hidden   = 1'b0;
    #1;
    check("async_reset", {bus.fuelPumpPower, bus.alarm, bus.stateOut}, 5'b0);
    repeat (2) @(negedge clock);
    check("reset_held", {bus.fuelPumpPower, bus.alarm, bus.stateOut}, 5'b0);
    reset = 1'b0;
    model_reset();
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (!reset && sb.size() > 0) begin
      e = sb.pop_front();
      check("cycle", {bus.fuelPumpPower, bus.alarm, bus.stateOut}, e);
    end
  end

  initial begin
    bus.ignition = 1'b0;
    bus.brake    = 1'b0;
    bus.hidden   = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check("reset_values", {bus.fuelPumpPower, bus.alarm, bus.stateOut}, 5'b0);
    reset = 1'b0;
    hold(2, 0, 0, 0);

    // Normal start, then ignition off.
    hold(3, 1, 0, 0);
    hold(2, 1, 1, 0);
    step(1, 1, 1);
    hold(5, 1, 1, 0);
    hold(4, 0, 0, 0);

    // Hidden held before brake: no arming, timeout back to WAIT_BRAKE.
    hold(3, 1, 0, 1);
    hold(11, 1, 1, 1);
    hold(3, 0, 0, 0);

    // Brake released mid-window, then a successful attempt.
    hold(3, 1, 0, 0);
    hold(5, 1, 1, 0);
    hold(2, 1, 0, 0);
    hold(3, 1, 1, 0);
    step(1, 1, 1);
    hold(4, 1, 1, 0);
    hold(4, 0, 0, 0);

    // Three consecutive timeouts into lockout and out again with ignition held.
    hold(3, 1, 0, 0);
    hold(60, 1, 1, 0);
    hold(4, 0, 0, 0);

    // hidRise on the last window cycle succeeds.
    hold(3, 1, 0, 0);
    step(1, 1, 0);
    hold(7, 1, 1, 0);
    step(1, 1, 1);
    hold(4, 1, 1, 1);
    hold(4, 0, 0, 0);

    // Ignition off on the timeout cycle: no fail; three more timeouts still needed.
    hold(3, 1, 0, 0);
    step(1, 1, 0);
    hold(7, 1, 1, 0);
    step(0, 0, 0);
    hold(4, 0, 0, 0);
    hold(3, 1, 0, 0);
    hold(50, 1, 1, 0);
    hold(4, 0, 0, 0);

    // Reset mid-RUN.
    hold(3, 1, 0, 0);
    hold(3, 1, 1, 0);
    step(1, 1, 1);
    hold(4, 1, 1, 0);
    apply_reset();
    hold(3, 0, 0, 0);

    // Randomized segments.
    for (int seg = 0; seg < 300; seg++) begin
      logic i, b, h;
      int   n;
      i = ($urandom_range(0, 9) < 8);
      b = ($urandom_range(0, 9) < 7);
      h = ($urandom_range(0, 9) < 3);
      n = h ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 12));
      hold(n, i, b, h);
      if (seg == 150) apply_reset();
    end
    hold(4, 0, 0, 0);

    @(posedge clock);
    #3;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
